esm_issue_scheduler: RTL and testbench
======================================

Name: esm_issue_scheduler

Overview:
- Slot allocator and issue arbiter for the ESM dependency-tracking core.
- Admits instructions into free buffer slots and drives the core's buffer_index for each admission.
- Stores each instruction word, and selects one dependency-free slot per cycle with a round-robin grant.
- Releases slots on completion and sits between fetch/decode and the execution units.

Parameters:
- Instr_word_size, 32, instruction word width.
- bs, 16, buffer slots; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream offers Instr_in.
- in_ready  output  1  a slot is free this cycle.
- Instr_in  input  Instr_word_size  offered instruction.
- alloc_fire  output  1  in_valid & in_ready; core writes IRT/IDT this cycle.
- buffer_index  output  $clog2(bs)  slot being allocated; valid when alloc_fire.
- ready_positions  input  bs  dependency-free slot mask from the core.
- issue_valid  output  1  issue_index/issue_instr hold a granted slot.
- issue_ready  input  1  downstream accepts the issue.
- issue_index  output  $clog2(bs)  granted slot.
- issue_instr  output  Instr_word_size  stored word of the granted slot.
- complete_valid  input  1  execution finished for complete_index.
- complete_index  input  $clog2(bs)  slot to release.
- occupancy  output  $clog2(bs)+1  number of valid slots.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst==0 at a clk edge): all state is cleared.
  - Outputs return to: in_ready=1, issue_valid=0, issue_index=0, issue_instr=0, occupancy=0, err=0, buffer_index=0.
  - Internal state: valid[]=0, issued[]=0, round-robin pointer rr=0.
  - Reset mid-operation discards every in-flight slot and any pending issue.
- Slot state per slot: FREE (valid=0), WAIT (valid=1, issued=0), ISSUED (valid=1, issued=1).
- Allocation:
  - buffer_index is the lowest-numbered FREE slot, computed combinationally from registered state.
  - in_ready = (occupancy < bs).
  - On alloc_fire: the slot becomes WAIT at the edge and mem[slot] <= Instr_in.
  - The core samples buffer_index on the same edge.
- Candidates: cand = valid & ~issued & ready_positions, excluding the slot currently presented on the issue port.
- Arbitration: performed when the issue register is empty, or is being emptied this cycle (issue_valid & issue_ready).
  - Grant goes to the first set bit of cand, searching from rr upward and wrapping modulo bs.
  - On grant: at the edge, issue_valid<=1, issue_index<=g, issue_instr<=mem[g], issued[g]<=1, rr<=(g+1) mod bs.
  - Latency: a slot allocated at edge N can appear on the issue port at edge N+1 at the earliest, provided the core reports it ready in that cycle.
- Issue handshake:
  - issue_valid/index/instr stay stable until issue_ready is sampled high.
  - Back-to-back issues are allowed: one issue per cycle at full throughput.
  - With no grant and issue_ready high, issue_valid<=0.
- Completion:
  - complete_valid on an ISSUED slot makes it FREE at the edge.
  - The freed slot is allocatable from the next cycle only; allocation never reuses a slot freed in the same cycle.
  - Completion of a FREE or WAIT slot: ignored, err<=1 (sticky until reset).
  - Completion may target the slot currently presented on the issue port once that issue has been accepted.
- occupancy:
  - Increments by 1 on alloc_fire; decrements by 1 on a legal completion.
  - Both in the same cycle leave it unchanged.
  - It never wraps.
- Full (occupancy==bs): in_ready=0 and Instr_in is ignored.
  - A completion in the same cycle does not raise in_ready until the next cycle.
- Empty: issue_valid stays 0 and no grant is made.
- Simultaneous alloc, grant and completion in one cycle are all legal and act on distinct slots.
  - The newly allocated slot is not a candidate in its allocation cycle.

Test Plan:
- Reset then fill:
  - Stimulus: rst low 2 cycles, then in_valid=1 for 16 cycles with Instr_in=0x100+k.
  - Required: buffer_index steps 0..15, occupancy reaches 16, in_ready=0 on cycle 17.
  - Required: the 17th word is not accepted.
- Round-robin fairness:
  - Stimulus: slots 0..15 in WAIT, ready_positions=0xFFFF, issue_ready=1.
  - Required: issue_index sequence 0,1,…,15, one per cycle, with issue_instr matching the stored words.
  - Stimulus: ready_positions=0x0011 after slot 4 was granted.
  - Required: the next grant is 0 (wrap), not 4.
- Backpressure:
  - Stimulus: issue_ready=0 for 5 cycles with slot 3 granted.
  - Required: issue_valid=1 and issue_index=3 stable for all 5 cycles; no other slot marked issued.
- Completion and reuse:
  - Stimulus: full buffer, complete slot 7.
  - Required: occupancy 16→15, in_ready=1 the next cycle, and the next allocation uses buffer_index=7.
- Illegal completion:
  - Stimulus: complete_index=9 while slot 9 is WAIT.
  - Required: slot 9 stays WAIT, occupancy unchanged, err=1 and held until rst.
- Reset mid-operation:
  - Stimulus: 6 valid slots with issue_valid=1, then rst low 1 cycle.
  - Required: next cycle occupancy=0, issue_valid=0, in_ready=1, buffer_index=0.

Source files
------------

// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler
// Slot allocator and round-robin issue arbiter for the ESM dependency-tracking
// core. It admits instructions into free buffer slots and reports each slot
// to the core through buffer_index. It stores the instruction words, grants
// one dependency-free slot per cycle to the issue port, and releases a slot
// when its execution completes.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-low reset
//   in_valid        upstream offers Instr_in
//   in_ready        a slot is free this cycle
//   Instr_in        offered instruction word
//   alloc_fire      in_valid & in_ready; the core writes IRT/IDT this cycle
//   buffer_index    slot being allocated (meaningful when alloc_fire)
//   ready_positions dependency-free slot mask from the core
//   issue_valid     issue_index/issue_instr hold a granted slot
//   issue_ready     downstream accepts the issue
//   issue_index     granted slot
//   issue_instr     stored word of the granted slot
//   complete_valid  execution finished for complete_index
//   complete_index  slot to release
//   occupancy       number of valid slots
//   err             sticky protocol error (completion of a non-issued slot)
module esm_issue_scheduler #(
    parameter int Instr_word_size = 32,
    parameter int bs              = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Instr_word_size-1:0] Instr_in,
    output logic                       alloc_fire,
    output logic [$clog2(bs)-1:0]      buffer_index,
    input  logic [bs-1:0]              ready_positions,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [$clog2(bs)-1:0]      issue_index,
    output logic [Instr_word_size-1:0] issue_instr,
    input  logic                       complete_valid,
    input  logic [$clog2(bs)-1:0]      complete_index,
    output logic [$clog2(bs):0]        occupancy,
    output logic                       err
);

    localparam int IW = $clog2(bs);
    localparam logic [IW:0] FULL_COUNT = (IW+1)'(bs);

    typedef logic [IW-1:0] idx_t;

    // Slot state: FREE (valid=0), WAIT (valid=1, issued=0), ISSUED (both 1).
    logic [bs-1:0]              valid;
    logic [bs-1:0]              issued;
    logic [Instr_word_size-1:0] mem [bs];
    idx_t                       rr;

    logic                       free_found;
    logic [bs-1:0]              presented;
    logic [bs-1:0]              cand;
    logic                       arb_en;
    logic                       grant_found;
    idx_t                       grant_idx;
    idx_t                       probe;
    logic                       comp_legal;

    // Lowest-numbered FREE slot, taken from registered state only, so a slot
    // released this cycle is never handed out before the next one.
    // NOTE: every signal driven here gets a default before the loop; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        free_found   = 1'b0;
        buffer_index = '0;
        for (int i = 0; i < bs; i++) begin
            if (!free_found && !valid[i]) begin
                free_found   = 1'b1;
                buffer_index = idx_t'(i);
            end
        end
    end

    assign in_ready   = (occupancy < FULL_COUNT);
    assign alloc_fire = in_valid & in_ready;

    // The slot sitting on the issue port is already ISSUED; masking it keeps
    // it out of arbitration even if the core still reports it ready.
    assign presented = issue_valid ? (bs'(1) << issue_index) : '0;
    assign cand      = valid & ~issued & ready_positions & ~presented;
    assign arb_en    = ~issue_valid | issue_ready;

    // Round-robin search: first candidate at or after rr, wrapping modulo bs
    // (the W-bit add wraps naturally because bs is a power of two).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int i = 0; i < bs; i++) begin
            probe = rr + idx_t'(i);
            if (!grant_found && cand[probe]) begin
                grant_found = 1'b1;
                grant_idx   = probe;
            end
        end
    end

    assign comp_legal = complete_valid & valid[complete_index] & issued[complete_index];

    // NOTE: the instruction store is deliberately not reset; a slot's word is
    // only ever read after the allocation that wrote it, and leaving it out of
    // reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem[buffer_index] <= Instr_in;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every update in
    // this block sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid       <= '0;
            issued      <= '0;
            rr          <= '0;
            issue_valid <= 1'b0;
            issue_index <= '0;
            issue_instr <= '0;
            occupancy   <= '0;
            err         <= 1'b0;
        end else begin
            // Allocation, completion and grant always target distinct slots:
            // allocation picks a FREE slot, a legal completion an ISSUED one,
            // and the grant a WAIT one.
            if (alloc_fire) begin
                valid[buffer_index]  <= 1'b1;
                issued[buffer_index] <= 1'b0;
            end

            if (comp_legal) begin
                valid[complete_index]  <= 1'b0;
                issued[complete_index] <= 1'b0;
            end else if (complete_valid) begin
                err <= 1'b1;
            end

            if (arb_en) begin
                if (grant_found) begin
                    issue_valid       <= 1'b1;
                    issue_index       <= grant_idx;
                    issue_instr       <= mem[grant_idx];
                    issued[grant_idx] <= 1'b1;
                    rr                <= grant_idx + idx_t'(1);
                end else begin
                    issue_valid <= 1'b0;
                end
            end

            case ({alloc_fire, comp_legal})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Self-checking bench for esm_issue_scheduler: directed steps for reset,
// fill, round-robin order and wrap, backpressure, completion/reuse, illegal
// completion and mid-operation reset, followed by a randomized phase. All
// expectations come from a slot-level reference model kept in this file.
module tb_esm_issue_scheduler;

    localparam int IWS = 32;
    localparam int BS  = 16;
    localparam int W   = $clog2(BS);

    typedef enum int {S_FREE, S_WAIT, S_ISSUED} slot_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [IWS-1:0] Instr_in;
    logic           alloc_fire;
    logic [W-1:0]   buffer_index;
    logic [BS-1:0]  ready_positions;
    logic           issue_valid;
    logic           issue_ready;
    logic [W-1:0]   issue_index;
    logic [IWS-1:0] issue_instr;
    logic           complete_valid;
    logic [W-1:0]   complete_index;
    logic [W:0]     occupancy;
    logic           err;

    esm_issue_scheduler #(.Instr_word_size(IWS), .bs(BS)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .Instr_in        (Instr_in),
        .alloc_fire      (alloc_fire),
        .buffer_index    (buffer_index),
        .ready_positions (ready_positions),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_index     (issue_index),
        .issue_instr     (issue_instr),
        .complete_valid  (complete_valid),
        .complete_index  (complete_index),
        .occupancy       (occupancy),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-slot state, stored words, issue port contents.
    slot_t          m_state [BS];
    logic [IWS-1:0] m_word  [BS];
    int             m_rr;
    bit             m_iv;
    int             m_ii;
    logic [IWS-1:0] m_instr;
    bit             m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_occ();
        int n = 0;
        for (int s = 0; s < BS; s++) if (m_state[s] != S_FREE) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int s = 0; s < BS; s++) if (m_state[s] == S_FREE) return s;
        return -1;
    endfunction

    // Apply one clock edge to the model using the inputs held before the edge.
    task automatic m_edge();
        int  a_slot;
        int  g;
        bit  fire;
        bit  arb;
        if (!rst) begin
            for (int s = 0; s < BS; s++) m_state[s] = S_FREE;
            m_rr = 0; m_iv = 0; m_ii = 0; m_instr = '0; m_err = 0;
            return;
        end
        fire   = in_valid && (m_occ() < BS);
        a_slot = m_lowest_free();
        arb    = !m_iv || issue_ready;
        g      = -1;
        if (arb) begin
            for (int i = 0; i < BS; i++) begin
                int s = (m_rr + i) % BS;
                if (g < 0 && m_state[s] == S_WAIT && ready_positions[s] && !(m_iv && m_ii == s))
                    g = s;
            end
        end
        if (complete_valid) begin
            if (m_state[complete_index] == S_ISSUED) m_state[complete_index] = S_FREE;
            else m_err = 1;
        end
        if (g >= 0) begin
            m_state[g] = S_ISSUED;
            m_iv = 1; m_ii = g; m_instr = m_word[g];
            m_rr = (g + 1) % BS;
        end else if (arb) begin
            m_iv = 0;
        end
        if (fire) begin
            m_state[a_slot] = S_WAIT;
            m_word[a_slot]  = Instr_in;
        end
    endtask

    // One cycle: check combinational outputs, clock, check registered outputs.
    task automatic step(input string tag);
        bit has_room;
        #1;
        has_room = (m_occ() < BS);
        check({tag, ":in_ready"}, 64'(in_ready), 64'(has_room));
        check({tag, ":alloc_fire"}, 64'(alloc_fire), 64'(in_valid && has_room));
        if (has_room) check({tag, ":buffer_index"}, 64'(buffer_index), 64'(m_lowest_free()));
        @(posedge clk);
        m_edge();
        #1;
        check({tag, ":issue_valid"}, 64'(issue_valid), 64'(m_iv));
        if (m_iv) begin
            check({tag, ":issue_index"}, 64'(issue_index), 64'(m_ii));
            check({tag, ":issue_instr"}, 64'(issue_instr), 64'(m_instr));
        end
        check({tag, ":occupancy"}, 64'(occupancy), 64'(m_occ()));
        check({tag, ":err"}, 64'(err), 64'(m_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order [7] = '{5, 6, 7, 8, 9, 1, 2};
        int picks [$];

        for (int s = 0; s < BS; s++) begin
            m_state[s] = S_FREE;
            m_word[s]  = '0;
        end
        m_rr = 0; m_iv = 0; m_ii = 0; m_instr = '0; m_err = 0;

        rst = 1'b0; in_valid = 1'b0; Instr_in = '0; ready_positions = '0;
        issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;

        // Reset for two cycles and check the reset state directly.
        step("rst0");
        step("rst1");
        check("rst:in_ready", 64'(in_ready), 64'd1);
        check("rst:issue_valid", 64'(issue_valid), 64'd0);
        check("rst:issue_index", 64'(issue_index), 64'd0);
        check("rst:issue_instr", 64'(issue_instr), 64'd0);
        check("rst:occupancy", 64'(occupancy), 64'd0);
        check("rst:err", 64'(err), 64'd0);
        check("rst:buffer_index", 64'(buffer_index), 64'd0);
        rst = 1'b1;

        // Fill all 16 slots, no grants.
        for (int k = 0; k < BS; k++) begin
            in_valid = 1'b1;
            Instr_in = 32'h100 + k;
            #1 check("fill:buffer_index", 64'(buffer_index), 64'(k));
            step("fill");
        end
        check("fill:occupancy", 64'(occupancy), 64'd16);
        Instr_in = 32'hDEAD_BEEF;
        #1 check("full:in_ready", 64'(in_ready), 64'd0);
        step("full");
        check("full:occupancy", 64'(occupancy), 64'd16);
        in_valid = 1'b0;

        // Round robin over every slot, one per cycle.
        ready_positions = '1;
        issue_ready     = 1'b1;
        for (int k = 0; k < BS; k++) begin
            step("rr");
            check("rr:index", 64'(issue_index), 64'(k));
            check("rr:instr", 64'(issue_instr), 64'(32'h100 + k));
        end
        step("rr_drain");
        check("rr_drain:issue_valid", 64'(issue_valid), 64'd0);
        ready_positions = '0;

        // Completion of slot 7 in a full buffer, then reuse.
        complete_valid = 1'b1; complete_index = 4'd7;
        in_valid = 1'b1; Instr_in = 32'h777;
        #1 check("cmp7:in_ready_same_cycle", 64'(in_ready), 64'd0);
        step("cmp7");
        check("cmp7:occupancy", 64'(occupancy), 64'd15);
        complete_valid = 1'b0;
        #1 check("reuse:in_ready", 64'(in_ready), 64'd1);
        check("reuse:buffer_index", 64'(buffer_index), 64'd7);
        step("reuse");
        check("reuse:occupancy", 64'(occupancy), 64'd16);
        in_valid = 1'b0;
        ready_positions = 16'h0080;
        step("latency");
        check("latency:index", 64'(issue_index), 64'd7);
        check("latency:instr", 64'(issue_instr), 64'h777);

        // Fresh start: ten slots in WAIT, then wrap-around grant.
        rst = 1'b0; ready_positions = '0;
        step("rst2");
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; Instr_in = 32'h200 + k;
            step("fill10");
        end
        in_valid = 1'b0;
        ready_positions = 16'h0010;
        step("grant4");
        check("grant4:index", 64'(issue_index), 64'd4);
        ready_positions = 16'h0011;
        step("wrap");
        check("wrap:index", 64'(issue_index), 64'd0);

        // Backpressure with slot 3 held; illegal completion of WAIT slot 9.
        ready_positions = 16'h0008;
        step("grant3");
        check("grant3:index", 64'(issue_index), 64'd3);
        issue_ready = 1'b0; ready_positions = '1;
        for (int c = 0; c < 5; c++) begin
            complete_valid = (c == 1);
            complete_index = 4'd9;
            step("bp");
            check("bp:valid", 64'(issue_valid), 64'd1);
            check("bp:index", 64'(issue_index), 64'd3);
            check("bp:instr", 64'(issue_instr), 64'h203);
        end
        complete_valid = 1'b0;
        check("illegal:err", 64'(err), 64'd1);
        check("illegal:occupancy", 64'(occupancy), 64'd10);
        issue_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step("release");
            check("release:index", 64'(issue_index), 64'(exp_order[k]));
        end
        check("sticky:err", 64'(err), 64'd1);

        // Reset mid-operation with an issue pending.
        issue_ready = 1'b0;
        check("midrst:pre_valid", 64'(issue_valid), 64'd1);
        rst = 1'b0;
        step("midrst");
        rst = 1'b1;
        check("midrst:occupancy", 64'(occupancy), 64'd0);
        check("midrst:issue_valid", 64'(issue_valid), 64'd0);
        check("midrst:in_ready", 64'(in_ready), 64'd1);
        check("midrst:buffer_index", 64'(buffer_index), 64'd0);
        check("midrst:err", 64'(err), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid        = ($urandom_range(0, 99) < 60);
            Instr_in        = $urandom;
            ready_positions = BS'($urandom);
            issue_ready     = ($urandom_range(0, 99) < 70);
            picks.delete();
            for (int s = 0; s < BS; s++)
                if (m_state[s] == S_ISSUED && !(m_iv && m_ii == s && !issue_ready))
                    picks.push_back(s);
            complete_valid = 1'b0;
            complete_index = '0;
            if (picks.size() > 0 && $urandom_range(0, 99) < 50) begin
                complete_valid = 1'b1;
                complete_index = W'(picks[$urandom_range(0, picks.size() - 1)]);
            end else if ($urandom_range(0, 199) == 0) begin
                complete_valid = 1'b1;
                complete_index = W'($urandom_range(0, BS - 1));
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
